// File: rtl/qpsk_ber_meter_if.sv
// Sample, reference and status bundle between the channel model and the BER meter.
// Master drives stimulus (start, reference bits, channel samples); slave returns counters and flags.
// The bundle carries no backpressure; every valid is taken or dropped by the slave.
interface qpsk_ber_meter_if #(
  parameter int BI = 12
);
  logic                 start;
  logic                 ref_valid;
  logic [1:0]           ref_bits;
  logic                 in_valid;
  logic signed [BI-1:0] y_real;
  logic signed [BI-1:0] y_imag;
  logic                 busy;
  logic                 done;
  logic [31:0]          bit_count;
  logic [31:0]          err_count;
  logic [31:0]          erase_count;
  logic                 ref_ovf;
  logic                 ref_unf;

  modport master (
    output start, ref_valid, ref_bits, in_valid, y_real, y_imag,
    input  busy, done, bit_count, err_count, erase_count, ref_ovf, ref_unf
  );

  modport slave (
    input  start, ref_valid, ref_bits, in_valid, y_real, y_imag,
    output busy, done, bit_count, err_count, erase_count, ref_ovf, ref_unf
  );
endinterface

// File: rtl/qpsk_ber_meter.sv
// Hard-decision QPSK slicer plus bit/error counters over a frame; BER_ERASURE_EN adds erasures.
// Latency: counters reflect a sample 2 cycles after it is presented (decision stage, count stage).
// No backpressure: full reference FIFO drops pushes (ref_ovf), empty FIFO drops samples (ref_unf).
module qpsk_ber_meter #(
  parameter int BI         = 12,
  parameter int FRAME_SYMS = 320000,
  parameter int FIFO_DEPTH = 16,
  parameter int ERASE_THR  = 16
) (
  input logic             clk,
  input logic             reset,
  qpsk_ber_meter_if.slave bus
);

`ifdef BER_ERASURE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              YW      = BI + 1;
  localparam logic [20:0]     FRAME_N = 21'(FRAME_SYMS);
  localparam logic [AW:0]     PTR_ONE = (AW + 1)'(1);
  localparam logic signed [YW-1:0] THR_S = YW'(ERASE_THR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]  mem_q [FIFO_DEPTH];
  logic        s1_vld_q, s1_vld_d;
  logic [1:0]  s1_dec_q, s1_dec_d;
  logic [1:0]  s1_ref_q, s1_ref_d;
  logic [1:0]  s1_ers_q, s1_ers_d;
  logic [19:0] sym_q, sym_d;
  logic [31:0] bit_cnt_q, bit_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [31:0] ers_cnt_q, ers_cnt_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic fifo_empty, fifo_full, accept, take, pop, push;
  logic [1:0] dec, ers;

  function automatic logic [1:0] popcnt2(input logic [1:0] a);
    return {a[1] & a[0], a[1] ^ a[0]};
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic is_small(input logic [BI-1:0] y);
    logic signed [YW-1:0] ye;
    ye = $signed({y[BI-1], y});
    return (ye < THR_S) && (ye > -THR_S);
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Stage 1 closes once committed plus in-flight symbols fill the frame.
  assign accept = (({1'b0, sym_q} + {20'b0, s1_vld_q}) < FRAME_N);
  assign take   = !bus.start && (state_q == S_RUN) && bus.in_valid && accept;
  assign pop    = take && !fifo_empty;
  assign push   = !bus.start && bus.ref_valid && (!fifo_full || pop);

  assign dec = {bus.y_imag[BI-1], bus.y_real[BI-1]};
  assign ers = {is_small(bus.y_imag) & ERASE_EN, is_small(bus.y_real) & ERASE_EN};

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    s1_vld_d  = 1'b0;
    s1_dec_d  = s1_dec_q;
    s1_ref_d  = s1_ref_q;
    s1_ers_d  = s1_ers_q;
    sym_d     = sym_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    ers_cnt_d = ers_cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    if (bus.start) begin
      state_d   = S_RUN;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      sym_d     = '0;
      bit_cnt_d = '0;
      err_cnt_d = '0;
      ers_cnt_d = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (bus.ref_valid && fifo_full && !pop) ovf_d = 1'b1;
      if (take && fifo_empty) unf_d = 1'b1;

      s1_vld_d = pop;
      if (pop) begin
        s1_dec_d = dec;
        s1_ref_d = mem_q[rd_ptr_q[AW-1:0]];
        s1_ers_d = ers;
      end

      if (s1_vld_q) begin
        bit_cnt_d = sat_add(bit_cnt_q, 2'd2 - popcnt2(s1_ers_q));
        err_cnt_d = sat_add(err_cnt_q, popcnt2((s1_dec_q ^ s1_ref_q) & ~s1_ers_q));
        ers_cnt_d = sat_add(ers_cnt_q, popcnt2(s1_ers_q));
        sym_d     = sym_q + 20'd1;
        if (({1'b0, sym_q} + 21'd1) == FRAME_N) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_dec_q  <= '0;
      s1_ref_q  <= '0;
      s1_ers_q  <= '0;
      sym_q     <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      ers_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_dec_q  <= s1_dec_d;
      s1_ref_q  <= s1_ref_d;
      s1_ers_q  <= s1_ers_d;
      sym_q     <= sym_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      ers_cnt_q <= ers_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q[AW-1:0]] <= bus.ref_bits;
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.bit_count   = bit_cnt_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.erase_count = ers_cnt_q;
  assign bus.ref_ovf     = ovf_q;
  assign bus.ref_unf     = unf_q;

endmodule

// File: doc/qpsk_ber_meter.md
# qpsk_ber_meter

Hard-decision QPSK slicer and bit-error-rate meter that sits directly downstream of the AWGN channel stage. It slices each noisy complex sample to two bits and compares them against the transmitted bits, which are buffered from the mapper in a reference FIFO. It accumulates bit and error counts over a programmable frame and then reports completion. It closes the loop for SNR sweeps in the text-implementation test system.

## Interface
- `BI`, 12: input sample width, signed two's complement.
- `FRAME_SYMS`, 320000: symbols per measurement frame, range 1 to 2^20-1.
- `FIFO_DEPTH`, 16: reference-bit FIFO depth, power of two.
- `ERASE_THR`, 16: erasure magnitude threshold. Used only with `BER_ERASURE_EN`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; clears counters and begins a frame.
- `ref_valid`  in  1  reference symbol present this cycle.
- `ref_bits`  in  2  transmitted bits; [0] is real, [1] is imag.
- `in_valid`  in  1  channel sample present this cycle.
- `y_real`  in  BI  channel output, real part, signed.
- `y_imag`  in  BI  channel output, imag part, signed.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `bit_count`  out  32  bits compared in the current frame.
- `err_count`  out  32  bit errors in the current frame.
- `erase_count`  out  32  erased bits in the current frame.
- `ref_ovf`  out  1  sticky flag: a reference push was dropped because the FIFO was full.
- `ref_unf`  out  1  sticky flag: a sample arrived while the FIFO was empty.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- `start` in any state takes effect on the next edge:
  - clears `bit_count`, `err_count`, `erase_count`, the symbol counter, `ref_ovf`, `ref_unf` and the FIFO;
  - enters RUN.
- `start` has priority over every other event in the same cycle. Any push, pop or count in that cycle is discarded.
- The FIFO accepts pushes in every state.
  - Push while full and no pop: data dropped, `ref_ovf` set.
  - Push while full with a simultaneous pop: accepted.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Samples are consumed only in RUN.
  - `in_valid` with FIFO non-empty: pop one entry and compare.
  - `in_valid` with FIFO empty: `ref_unf` set, sample discarded, no count. There is no bypass of a same-cycle push.
  - `in_valid` in IDLE or DONE: ignored, no pop.
- Slicing: decided bit = sign bit of the component (negative → 1). Zero slices to 0.
- Per compared symbol:
  - `bit_count` increases by 2.
  - `err_count` increases by popcount(decided XOR ref), i.e. 0, 1 or 2.
  - The symbol counter increases by 1.
- All 32-bit counters saturate at 0xFFFFFFFF.
- When the symbol counter reaches `FRAME_SYMS`, the FSM goes RUN → DONE. DONE holds, with counters frozen, until `start` or reset.

## Timing
- Pipeline stage 1: the edge that samples `in_valid` registers the decision, the popped reference and the valid tag.
- Pipeline stage 2: the following edge updates the counters.
- Counters therefore reflect a sample 2 cycles after it is presented.
- `done` rises on the same edge as the final count update, i.e. 2 cycles after the last sample. `busy` falls on that same edge.
- Samples presented in the cycle before the final update are still counted, because the in-flight stage is drained. The frame never exceeds `FRAME_SYMS` because stage 1 stops accepting once the committed count plus the in-flight count equals `FRAME_SYMS`.
- Reset values: all counters 0, flags 0, `busy` 0, `done` 0, FIFO empty, pipeline empty.
- Reset mid-frame aborts the frame and drops any in-flight sample.
- Back-to-back `in_valid` is supported at one sample per cycle.

## Configuration
- `BER_ERASURE_EN` defined:
  - A component with |y| < `ERASE_THR` is an erasure.
  - Each erased bit increments `erase_count` and is neither an error nor counted in `bit_count`.
  - `bit_count` increases by 2 minus the number of erased bits.
- `BER_ERASURE_EN` undefined:
  - `erase_count` is tied to 0.
  - All bits are sliced and counted as described in Operation.

## Test plan
- Reset low 2 cycles, then high → all outputs 0, state IDLE; `in_valid` with y=(100,-100) changes nothing.
- `start`; push ref 2'b10; sample (100,-100) → 2 cycles later `bit_count`=2, `err_count`=0.
- `FRAME_SYMS`=4; four samples (-50,-50) against ref 2'b00 → `err_count`=8, `bit_count`=8; `done` rises 2 cycles after the 4th sample; a 5th sample is ignored.
- 17 pushes with no pops → `ref_ovf`=1; 16 pops later a further `in_valid` sets `ref_unf`=1.
- `BER_ERASURE_EN`; sample (5,-200) against ref 2'b00 → `erase_count`=1, `bit_count`=1, `err_count`=1.
- Reset asserted mid-frame after 3 symbols → counters 0 the next cycle; a pre-reset in-flight sample is never counted.
